// File: rtl/hazard_mc_pkg.sv
// Shared encodings for the hazard unit: writeback-source codes that mark loads
// and the operand-select values used by the execute-stage forwarding muxes.
package hazard_pkg;

  localparam logic [3:0] WB_LOAD   = 4'b1111;
  localparam logic [3:0] WB_LOAD_M = 4'b1110;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_mc_track.sv
// Scoreboard entry for one multi-cycle unit: busy flag, destination register,
// watchdog counter with a one-cycle abort pulse, and the structural stall request.
module mc_track #(
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 6,
  parameter int MAX_LAT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done,
  input  logic              issue,
  input  logic [REG_AW-1:0] dest_in,
  output logic              busy,
  output logic [REG_AW-1:0] dest,
  output logic              timeout,
  output logic              stall_req
);

  logic              busy_reg;
  logic [REG_AW-1:0] dest_reg;
  logic [LAT_W-1:0]  cnt_reg;
  logic              timeout_reg;

  // A start always wins: a done arriving on the same edge belongs to the old op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= 1'b0;
      dest_reg    <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (start) begin
        busy_reg <= 1'b1;
        dest_reg <= dest_in;
        cnt_reg  <= '0;
      end else if (busy_reg && done) begin
        busy_reg <= 1'b0;
      end else if (busy_reg && cnt_reg == LAT_W'(MAX_LAT - 1)) begin
        busy_reg    <= 1'b0;
        timeout_reg <= 1'b1;
      end else if (busy_reg) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign busy      = busy_reg;
  assign dest      = dest_reg;
  assign timeout   = timeout_reg;
  assign stall_req = issue && (busy_reg || start);

endmodule

// File: rtl/hazard_mc.sv
// Pipeline hazard unit with a per-unit multi-cycle scoreboard: forwarding,
// load-use and branch stalls, plus structural and pending-result stalls.
module hazard_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_MC  = 2,
  parameter int LAT_W   = 6,
  parameter int MAX_LAT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        branchD,
  input  logic [3:0]        wbsrcE,
  input  logic [3:0]        wbsrcM,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic [NUM_MC-1:0] mc_issueD,
  input  logic [NUM_MC-1:0] mc_startE,
  input  logic [REG_AW-1:0] mc_destE,
  input  logic [NUM_MC-1:0] mc_done,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic [NUM_MC-1:0] mc_busy,
  output logic [NUM_MC-1:0] mc_timeout
);

  logic [NUM_MC-1:0] struct_req;
  logic [NUM_MC-1:0] data_req;
  logic [REG_AW-1:0] unit_dest [NUM_MC];
  logic              new_dest_hit;
  logic              lw_stall;
  logic              br_stall;
  logic              any_stall;

  assign new_dest_hit = (mc_destE != '0) && (rsD == mc_destE || rtD == mc_destE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MC; gi++) begin : g_unit
      mc_track #(
        .REG_AW  (REG_AW),
        .LAT_W   (LAT_W),
        .MAX_LAT (MAX_LAT)
      ) u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mc_startE[gi]),
        .done      (mc_done[gi]),
        .issue     (mc_issueD[gi]),
        .dest_in   (mc_destE),
        .busy      (mc_busy[gi]),
        .dest      (unit_dest[gi]),
        .timeout   (mc_timeout[gi]),
        .stall_req (struct_req[gi])
      );

      // Pending result: either already tracked, or entering the unit right now.
      assign data_req[gi] =
          (mc_busy[gi] && unit_dest[gi] != '0 &&
           (rsD == unit_dest[gi] || rtD == unit_dest[gi])) ||
          (mc_startE[gi] && new_dest_hit);
    end
  endgenerate

  assign lw_stall = (wbsrcE == WB_LOAD) && (rtE != '0) && (rsD == rtE || rtD == rtE);

  assign br_stall = (branchD != 2'b00) &&
      ((regwriteE && writeregE != '0 && (rsD == writeregE || rtD == writeregE)) ||
       (wbsrcM == WB_LOAD_M && writeregM != '0 && (rsD == writeregM || rtD == writeregM)));

  assign any_stall = lw_stall || br_stall || (|struct_req) || (|data_req);
  assign stallF    = any_stall;
  assign stallD    = any_stall;
  assign flushE    = any_stall;

  always_comb begin
    forwardAE = FWD_RF;
    if (rsE != '0 && regwriteM && writeregM == rsE)      forwardAE = FWD_MEM;
    else if (rsE != '0 && regwriteW && writeregW == rsE) forwardAE = FWD_WB;
  end

  always_comb begin
    forwardBE = FWD_RF;
    if (rtE != '0 && regwriteM && writeregM == rtE)      forwardBE = FWD_MEM;
    else if (rtE != '0 && regwriteW && writeregW == rtE) forwardBE = FWD_WB;
  end

  assign forwardAD = (rsD != '0) && regwriteM && (writeregM == rsD);
  assign forwardBD = (rtD != '0) && regwriteM && (writeregM == rtD);

endmodule

// File: tb/tb_hazard_mc.sv
// Randomised check of hazard_mc against a cycle-stamp scoreboard model,
// preceded by directed scenarios with hand-computed expectations.
module tb_hazard_mc;
  localparam int REG_AW  = 5;
  localparam int NUM_MC  = 2;
  localparam int LAT_W   = 6;
  localparam int MAX_LAT = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        branchD;
  logic [3:0]        wbsrcE, wbsrcM;
  logic              regwriteE, regwriteM, regwriteW;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic [NUM_MC-1:0] mc_issueD, mc_startE, mc_done;
  logic [REG_AW-1:0] mc_destE;
  logic              stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0]        forwardAE, forwardBE;
  logic [NUM_MC-1:0] mc_busy, mc_timeout;

  always #5 clk = ~clk;

  hazard_mc #(.REG_AW(REG_AW), .NUM_MC(NUM_MC), .LAT_W(LAT_W), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .branchD(branchD), .wbsrcE(wbsrcE), .wbsrcM(wbsrcM),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .mc_issueD(mc_issueD), .mc_startE(mc_startE), .mc_destE(mc_destE), .mc_done(mc_done),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each unit remembers the cycle stamp of its start; it expires when
  // MAX_LAT edges have elapsed without a done.
  bit              m_busy [NUM_MC];
  bit              m_to   [NUM_MC];
  logic [REG_AW-1:0] m_dest [NUM_MC];
  longint          m_t0   [NUM_MC];
  longint          cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MC; i++) begin
        m_busy[i] <= 1'b0;
        m_to[i]   <= 1'b0;
        m_dest[i] <= '0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < NUM_MC; i++) begin
        m_to[i] <= 1'b0;
        if (mc_startE[i]) begin
          m_busy[i] <= 1'b1;
          m_dest[i] <= mc_destE;
          m_t0[i]   <= cyc;
        end else if (m_busy[i] && mc_done[i]) begin
          m_busy[i] <= 1'b0;
        end else if (m_busy[i] && (cyc - m_t0[i]) == MAX_LAT) begin
          m_busy[i] <= 1'b0;
          m_to[i]   <= 1'b1;
        end
      end
    end
  end

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src);
    if (src == 0) return 2'd0;
    if (regwriteM && writeregM == src) return 2'd2;
    if (regwriteW && writeregW == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit reads(input logic [REG_AW-1:0] r);
    return r != 0 && (rsD == r || rtD == r);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_stall;
      logic [NUM_MC-1:0] exp_busy, exp_to;
      exp_stall = (wbsrcE == 4'hF && reads(rtE)) ||
                  (branchD != 0 && ((regwriteE && reads(writeregE)) ||
                                    (wbsrcM == 4'hE && reads(writeregM))));
      for (int i = 0; i < NUM_MC; i++) begin
        exp_busy[i] = m_busy[i];
        exp_to[i]   = m_to[i];
        if (mc_issueD[i] && (m_busy[i] || mc_startE[i])) exp_stall = 1'b1;
        if (m_busy[i] && reads(m_dest[i]))             exp_stall = 1'b1;
        if (mc_startE[i] && reads(mc_destE))           exp_stall = 1'b1;
      end
      check("stall", {29'd0, stallF, stallD, flushE}, {29'd0, {3{exp_stall}}});
      check("forwardAE", {30'd0, forwardAE}, {30'd0, fwd_e(rsE)});
      check("forwardBE", {30'd0, forwardBE}, {30'd0, fwd_e(rtE)});
      check("forwardAD", {31'd0, forwardAD}, {31'd0, rsD != 0 && regwriteM && writeregM == rsD});
      check("forwardBD", {31'd0, forwardBD}, {31'd0, rtD != 0 && regwriteM && writeregM == rtD});
      check("mc_busy", {30'd0, mc_busy}, {30'd0, exp_busy});
      check("mc_timeout", {30'd0, mc_timeout}, {30'd0, exp_to});
    end
  end

  task automatic clear_inputs();
    branchD = 0; wbsrcE = 0; wbsrcM = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    mc_issueD = 0; mc_startE = 0; mc_destE = 0; mc_done = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  function automatic logic [NUM_MC-1:0] rand_onehot(input int zero_weight);
    int r;
    r = int'($urandom_range(0, 1 + zero_weight));
    if (r == 0) return 2'b01;
    if (r == 1) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset_busy", {30'd0, mc_busy}, 32'd0);
    check("reset_timeout", {30'd0, mc_timeout}, 32'd0);
    check("reset_stall", {29'd0, stallF, stallD, flushE}, 32'd0);
    check("reset_fwd", {26'd0, forwardAE, forwardBE, forwardAD, forwardBD}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Forwarding priority and register 0
    next_cycle();
    rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    @(negedge clk);
    check("fwd_mem_prio", {30'd0, forwardAE}, 32'd2);
    regwriteM = 0; #1;
    check("fwd_wb", {30'd0, forwardAE}, 32'd1);
    regwriteM = 1; rsE = 0; #1;
    check("fwd_r0", {30'd0, forwardAE}, 32'd0);

    // Load-use
    next_cycle();
    wbsrcE = 4'hF; rtE = 5; rsD = 5;
    @(negedge clk);
    check("loaduse", {29'd0, stallF, stallD, flushE}, 32'd7);
    next_cycle();
    wbsrcE = 4'hF; rtE = 0;
    @(negedge clk);
    check("loaduse_r0", {31'd0, stallF}, 32'd0);

    // Independent op while unit 0 busy, then dependent stall until after done
    next_cycle();
    mc_startE = 2'b01; mc_destE = 8; rsD = 9; rtD = 10;
    @(negedge clk);
    check("start_nostall", {31'd0, stallF}, 32'd0);
    next_cycle();
    rsD = 9; rtD = 10;
    @(negedge clk);
    check("busy_set", {30'd0, mc_busy}, 32'd1);
    check("indep_nostall", {31'd0, stallF}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      rsD = 8;
      @(negedge clk);
      check("dep_stall", {31'd0, stallD}, 32'd1);
    end
    next_cycle();
    rsD = 8; mc_done = 2'b01;
    @(negedge clk);
    check("done_cycle_stall", {31'd0, stallD}, 32'd1);
    next_cycle();
    rsD = 8;
    @(negedge clk);
    check("released", {31'd0, stallD}, 32'd0);
    check("busy_cleared", {30'd0, mc_busy}, 32'd0);

    // Structural
    next_cycle();
    mc_startE = 2'b01;
    next_cycle();
    mc_issueD = 2'b01;
    @(negedge clk);
    check("struct_busy", {31'd0, flushE}, 32'd1);
    mc_issueD = 2'b10; #1;
    check("struct_idle", {31'd0, flushE}, 32'd0);
    next_cycle();
    mc_done = 2'b01;

    // Start and done together: start wins
    next_cycle();
    mc_startE = 2'b01; mc_destE = 4;
    next_cycle();
    mc_startE = 2'b01; mc_destE = 6; mc_done = 2'b01;
    next_cycle();
    rsD = 6;
    @(negedge clk);
    check("sim_busy", {30'd0, mc_busy}, 32'd1);
    check("sim_newdest", {31'd0, stallF}, 32'd1);
    rsD = 4; #1;
    check("sim_olddest", {31'd0, stallF}, 32'd0);
    next_cycle();
    mc_done = 2'b01;

    // Watchdog on unit 1
    next_cycle();
    mc_startE = 2'b10;
    for (int k = 0; k <= 41; k++) begin
      next_cycle();
      @(negedge clk);
      if (k == 39) check("wd_pre", {28'd0, mc_busy, mc_timeout}, 32'b1000);
      if (k == 40) check("wd_fire", {28'd0, mc_busy, mc_timeout}, 32'b0010);
      if (k == 41) check("wd_post", {28'd0, mc_busy, mc_timeout}, 32'b0000);
    end

    // Reset mid-operation, later done ignored
    next_cycle();
    mc_startE = 2'b01; mc_destE = 3;
    next_cycle();
    mc_startE = 2'b10; mc_destE = 4;
    next_cycle();
    @(negedge clk);
    check("both_busy", {30'd0, mc_busy}, 32'd3);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {30'd0, mc_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    mc_done = 2'b11;
    @(negedge clk);
    check("done_after_reset", {30'd0, mc_busy}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 299) != 0);
      branchD   = 2'($urandom_range(0, 3));
      wbsrcE    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      wbsrcM    = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
      regwriteE = 1'($urandom);
      regwriteM = 1'($urandom);
      regwriteW = 1'($urandom);
      rsD       = REG_AW'($urandom_range(0, 7));
      rtD       = REG_AW'($urandom_range(0, 7));
      rsE       = REG_AW'($urandom_range(0, 7));
      rtE       = REG_AW'($urandom_range(0, 7));
      writeregE = REG_AW'($urandom_range(0, 7));
      writeregM = REG_AW'($urandom_range(0, 7));
      writeregW = REG_AW'($urandom_range(0, 7));
      mc_issueD = rand_onehot(2);
      mc_startE = rand_onehot(10);
      mc_destE  = REG_AW'($urandom_range(0, 7));
      for (int i = 0; i < NUM_MC; i++) mc_done[i] = ($urandom_range(0, 29) == 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_mc.md
Name: hazard_mc

Overview:
- Parametrised successor to the pipeline hazard unit: same load-use, branch-compare and forwarding logic, generalised to NUM_MC independent multi-cycle execution units (mult, div, ...).
- Replaces the single global "multiplier busy" flag with a per-unit scoreboard: busy bit, destination register and watchdog counter per unit.
- Stalls only decode instructions that depend on a pending result, or that target a busy unit, instead of freezing the pipeline for every multi-cycle op.
- Sits between the decode/execute/memory/writeback pipeline registers and the multi-cycle units.

Parameters:
- REG_AW, 5: register-address width.
- NUM_MC, 2: number of multi-cycle units tracked.
- LAT_W, 6: watchdog counter width.
- MAX_LAT, 40: busy-cycle limit before the watchdog aborts a unit (must be < 2**LAT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- branchD  in  2  non-zero = branch in D.
- wbsrcE, wbsrcM  in  4 each  writeback-source code in E/M.
- regwriteE, regwriteM, regwriteW  in  1 each  stage writes the register file.
- rsD, rtD, rsE, rtE  in  REG_AW each  source registers.
- writeregE, writeregM, writeregW  in  REG_AW each  destination registers.
- mc_issueD  in  NUM_MC  one-hot or zero; the D instruction targets unit i.
- mc_startE  in  NUM_MC  one-hot or zero; the op for unit i enters E this cycle.
- mc_destE  in  REG_AW  destination of the started op; 0 = none.
- mc_done  in  NUM_MC  unit i has its result valid this cycle (1-cycle pulse).
- stallF, stallD, flushE  out  1 each  pipeline control.
- forwardAD, forwardBD  out  1 each  M→D forward for the branch comparator.
- forwardAE, forwardBE  out  2 each  E operand select.
- mc_busy  out  NUM_MC  scoreboard busy bits.
- mc_timeout  out  NUM_MC  1-cycle pulse; watchdog aborted unit i.

Behaviour:
- Reset (async, rst_n=0):
  - busy, dest, counters and mc_timeout all clear to 0.
  - With every input at 0, all combinational outputs are 0.
- Forwarding (combinational; source register 0 never forwards):
  - forwardAE/BE: 10 = M match with regwriteM (has priority); 01 = W match with regwriteW; else 00.
  - forwardAD/BD: 1 on M match with regwriteM.
- Load-use stall: wbsrcE == WB_LOAD, rtE != 0, and (rsD == rtE or rtD == rtE).
- Branch stall: branchD != 0 and either of:
  - regwriteE, writeregE != 0, and rsD or rtD == writeregE;
  - wbsrcM == WB_LOAD_M and rsD or rtD == writeregM (writeregM != 0).
- Scoreboard, per unit i (edge-triggered):
  - mc_startE[i]: busy ← 1, dest ← mc_destE, counter ← 0.
  - Else if busy and mc_done[i]: busy ← 0.
  - Else if busy and counter == MAX_LAT-1: busy ← 0, mc_timeout[i] ← 1 for exactly one cycle.
  - Else if busy: counter increments.
  - Start and done on the same unit in the same cycle: start wins (new op tracked, old one considered complete).
  - mc_done while not busy is ignored.
- Structural stall: mc_issueD[i] and (busy[i] or mc_startE[i]).
- Data stall, either of:
  - busy[i], dest[i] != 0, rsD or rtD == dest[i];
  - mc_startE[i], mc_destE != 0, rsD or rtD == mc_destE.
- Stall timing:
  - Stall holds through the done cycle and releases the cycle after mc_done.
  - The result is then forwarded through the normal M/W path.
- Stall composition: any stall condition asserts stallF = stallD = flushE = 1 in the same cycle.
- No stall on start alone: independent instructions continue while units are busy.
- Reset mid-operation clears every busy bit immediately; a mc_done pulse after reset is ignored.
- Latency: forwarding and stall decode are combinational (0 cycles); scoreboard updates are visible the cycle after the edge.

Decomposition:
- Package hazard_pkg holds:
  - WB_LOAD = 4'b1111, WB_LOAD_M = 4'b1110;
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- Sub-module mc_track: one instance per unit via generate.
  - Holds busy, dest, watchdog counter and timeout pulse.
  - Outputs busy, dest and a per-unit stall request.
- Top level: OR-reduces the unit stall requests with the load-use and branch terms, and contains the forwarding logic.

Test Plan:
- Forwarding: rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 → forwardAE=10; rsE=0 with the same M/W values → forwardAE=00.
- Load-use: wbsrcE=1111, rtE=5, rsD=5 → stallF=stallD=flushE=1 for one cycle; rtE=0 → no stall.
- Independent op while busy:
  - mc_startE=01, mc_destE=8 → mc_busy=01.
  - Next D instruction reads regs 9/10 → no stall.
  - D reads rsD=8 → stall until the cycle after mc_done[0], then released.
- Structural: unit 0 busy, mc_issueD=01 → stall; mc_issueD=10 with unit 1 idle → no stall.
- Watchdog: MAX_LAT=40, start unit 1, never assert mc_done → mc_timeout[1] pulses for 1 cycle, 40 cycles after busy sets; busy clears on the same edge.
- Reset and simultaneous events:
  - rst_n low with both units busy → mc_busy=00 immediately; a later mc_done is ignored.
  - mc_startE[0] together with mc_done[0] → busy stays 1 with the new dest.
